// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, reduction polynomial and GF(2^8) helpers
// used by the InvMixColumns datapath.
package aes_pkg;

  localparam int unsigned STATE_W  = 128;
  localparam logic [7:0]  AES_POLY = 8'h1B;

  // One byte plus its x2/x4/x8 multiples; the 09/0b/0d/0e products are XORs of these.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
  } gf_mults_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic gf_mults_t gf_expand(input logic [7:0] b);
    gf_mults_t m;
    m.a  = b;
    m.x2 = xtime(b);
    m.x4 = xtime(m.x2);
    m.x8 = xtime(m.x4);
    return m;
  endfunction

  function automatic logic [7:0] gf_comb09(input gf_mults_t m);
    return m.x8 ^ m.a;
  endfunction

  function automatic logic [7:0] gf_comb0b(input gf_mults_t m);
    return m.x8 ^ m.x2 ^ m.a;
  endfunction

  function automatic logic [7:0] gf_comb0d(input gf_mults_t m);
    return m.x8 ^ m.x4 ^ m.a;
  endfunction

  function automatic logic [7:0] gf_comb0e(input gf_mults_t m);
    return m.x8 ^ m.x4 ^ m.x2;
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] b);
    return gf_comb09(gf_expand(b));
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
    return gf_comb0b(gf_expand(b));
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
    return gf_comb0d(gf_expand(b));
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
    return gf_comb0e(gf_expand(b));
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// One 32-bit InvMixColumns column, split into an expand half (byte -> x2/x4/x8)
// and a combine half so the parent can optionally register between them.
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic                 [31:0] col_i,
  output gf_mults_t [3:0]             mults_o,
  input  gf_mults_t [3:0]             mults_i,
  output logic                 [31:0] col_o
);

  // mults index r corresponds to byte r of the column; byte 0 is the top byte.
  always_comb begin
    mults_o    = '0;
    mults_o[0] = gf_expand(col_i[31:24]);
    mults_o[1] = gf_expand(col_i[23:16]);
    mults_o[2] = gf_expand(col_i[15:8]);
    mults_o[3] = gf_expand(col_i[7:0]);
  end

  always_comb begin
    col_o        = '0;
    col_o[31:24] = gf_comb0e(mults_i[0]) ^ gf_comb0b(mults_i[1])
                 ^ gf_comb0d(mults_i[2]) ^ gf_comb09(mults_i[3]);
    col_o[23:16] = gf_comb09(mults_i[0]) ^ gf_comb0e(mults_i[1])
                 ^ gf_comb0b(mults_i[2]) ^ gf_comb0d(mults_i[3]);
    col_o[15:8]  = gf_comb0d(mults_i[0]) ^ gf_comb09(mults_i[1])
                 ^ gf_comb0e(mults_i[2]) ^ gf_comb0b(mults_i[3]);
    col_o[7:0]   = gf_comb0b(mults_i[0]) ^ gf_comb0d(mults_i[1])
                 ^ gf_comb09(mults_i[2]) ^ gf_comb0e(mults_i[3]);
  end

endmodule

// File: rtl/inv_mix_columns.sv
// Streaming AES InvMixColumns over a full 128-bit state, four columns in parallel.
// Define INV_MIX_COLUMNS_PIPE2_EN for 2-cycle latency; default is 1-cycle.
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [0:STATE_W-1] in_data,
  input  logic               in_ready,
  output logic [0:STATE_W-1] out_data,
  output logic               out_ready
);

  gf_mults_t [3:0][3:0] mults_in;
  gf_mults_t [3:0][3:0] mults_st;
  logic      [31:0]     col_res [4];
  logic [0:STATE_W-1]   out_d;
  logic [0:STATE_W-1]   out_q;

  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_column_word u_word (
      .col_i   (in_data[32*c +: 32]),
      .mults_o (mults_in[c]),
      .mults_i (mults_st[c]),
      .col_o   (col_res[c])
    );
  end

  always_comb begin
    out_d = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      out_d[32*c +: 32] = col_res[c];
    end
  end

`ifdef INV_MIX_COLUMNS_PIPE2_EN
  gf_mults_t [3:0][3:0] mults_q;
  logic                 vld1_q;
  logic                 vld2_q;

  assign mults_st = mults_q;

  // Each stage loads only behind its own valid bit, so idle cycles hold data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mults_q <= '0;
      vld1_q  <= 1'b0;
      out_q   <= '0;
      vld2_q  <= 1'b0;
    end else begin
      vld1_q <= in_ready;
      vld2_q <= vld1_q;
      if (in_ready) mults_q <= mults_in;
      if (vld1_q)   out_q   <= out_d;
    end
  end

  assign out_ready = vld2_q;
`else
  logic vld_q;

  assign mults_st = mults_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_ready;
      if (in_ready) out_q <= out_d;
    end
  end

  assign out_ready = vld_q;
`endif

  assign out_data = out_q;

endmodule
